cp0_tlb_ctrl: RTL and testbench
===============================

CP0_TLB_CTRL -- requirements
Module: cp0_tlb_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of TLB entries; index width IW = clog2(TLBNUM).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
REQ-004 SHALL have ports: mtc0_we in 1, mtc0_addr in 8 ({rd[4:0],sel[2:0]}), mtc0_wdata in 32  CP0 register write.
REQ-005 SHALL have ports: mfc0_addr in 8, mfc0_rdata out 32  combinational CP0 register read.
REQ-006 SHALL have ports: op_valid in 1, op_tlbp/op_tlbr/op_tlbwi in 1 each, op_ready out 1, op_done out 1  TLB-op handshake.
REQ-007 SHALL have ports: s_vpn2 out 19, s_asid out 8, s_found in 1, s_index in IW  TLB search port.
REQ-008 SHALL have ports: r_index out IW; r_vpn2 in 19, r_asid in 8, r_g in 1, r_pfn0/r_pfn1 in 20, r_c0/r_c1 in 3, r_d0/r_d1/r_v0/r_v1 in 1  TLB read port.
REQ-009 SHALL have ports: we out 1, w_index out IW, w_vpn2 19, w_asid 8, w_g 1, w_pfn0/w_pfn1 20, w_c0/w_c1 3, w_d0/w_d1/w_v0/w_v1 1, all out  TLB write port.
REQ-010 SHALL have ports: entryhi_out out 32  current EntryHi for address translation (ASID source).

Function
REQ-011 SHALL hold Index (addr {0,0}), EntryLo0 ({2,0}), EntryLo1 ({3,0}), EntryHi ({10,0}); other addresses read 0 and ignore writes.
REQ-012 SHALL keep EntryHi as VPN2[31:13], ASID[7:0], other bits read 0.
REQ-013 SHALL keep EntryLoN as PFN[25:6], C[5:3], D[2], V[1], G[0], bits 31:26 read 0.
REQ-014 SHALL keep Index as P[31], index[IW-1:0], other bits read 0; mtc0 writes index bits only, P unchanged.
REQ-015 SHALL apply mtc0 only when state==IDLE; mtc0_we in any other state is dropped.
REQ-016 SHALL implement states IDLE, PROBE, READ, WRITE, DONE; op_ready = (state==IDLE).
REQ-017 SHALL accept an op when op_valid & op_ready; priority tlbp > tlbr > tlbwi; op_valid with no op flag set is ignored, state stays IDLE.
REQ-018 SHALL on accepted tlbp go IDLE->PROBE->DONE; in PROBE, at the clock edge, Index <= s_found ? {P=0, s_index} : {P=1, index bits unchanged}.
REQ-019 SHALL drive s_vpn2 = EntryHi[31:13] and s_asid = EntryHi[7:0] continuously.
REQ-020 SHALL on accepted tlbr go IDLE->READ->DONE; r_index = Index index bits continuously; in READ, at the edge, load EntryHi {r_vpn2, 5'b0, r_asid}, EntryLo0 {r_pfn0,r_c0,r_d0,r_v0,r_g}, EntryLo1 likewise.
REQ-021 SHALL on accepted tlbwi go IDLE->WRITE->DONE; we=1 only during WRITE, exactly one cycle; w_index = Index bits; w_g = EntryLo0.G & EntryLo1.G; other w_* fields taken from EntryHi/EntryLoN.
REQ-022 SHALL assert op_done for exactly the one DONE cycle, then return to IDLE; op latency accept->done = 2 cycles.
REQ-023 SHALL, when mtc0_we and an op are accepted on the same IDLE edge, apply the mtc0 first; the op uses updated values.
REQ-024 SHALL make mfc0_rdata reflect a register update from the cycle after the updating edge.
REQ-025 SHALL drive entryhi_out = EntryHi register value.

Reset
REQ-026 SHALL on reset immediately clear state to IDLE, all four registers to 0, we/op_done to 0, op_ready to 1.
REQ-027 SHALL abort an in-flight op when reset asserts mid-op; no write pulse, no register update occurs.

Verification
REQ-028 SHALL cover: mtc0 EntryHi=0x0000_2005, tlbp, s_found=1 s_index=3 -> Index reads 0x0000_0003, op_done 2 cycles after accept.
REQ-029 SHALL cover: tlbp with s_found=0, Index previously 5 -> Index reads 0x8000_0005.
REQ-030 SHALL cover: Index=7, EntryLo0 G=1, EntryLo1 G=0, tlbwi -> one-cycle we, w_index=7, w_g=0.
REQ-031 SHALL cover: tlbr, r_vpn2=0x12345, r_asid=0x0A, r_g=1, r_pfn0=0xABCDE -> EntryHi=0x2468_A00A, EntryLo0[25:6]=0xABCDE, G=1 in both EntryLo.
REQ-032 SHALL cover: mtc0 during PROBE dropped; op_valid with tlbp+tlbwi both set -> probe only, we never asserted.
REQ-033 SHALL cover: reset asserted in WRITE -> we drops immediately, state IDLE, registers 0.

Source files
------------

// File: rtl/cp0_tlb_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_tlb_ctrl
//
// Purpose:
//   CP0 register slice that owns the TLB-related registers (Index, EntryLo0,
//   EntryLo1, EntryHi) and sequences the TLBP / TLBR / TLBWI instructions
//   against an external TLB array through its search, read and write ports.
//
// Ports:
//   clk, reset          - clock (rising edge) and asynchronous active-high reset
//   mtc0_we/addr/wdata  - CP0 register write, addr = {rd[4:0], sel[2:0]}
//   mfc0_addr/rdata     - combinational CP0 register read
//   op_valid, op_tlbp,
//   op_tlbr, op_tlbwi   - TLB instruction request (valid plus one-hot-ish flags)
//   op_ready, op_done   - request accepted when ready; done pulses once
//   s_*                 - TLB search port (key out, hit/index in)
//   r_*                 - TLB read port (index out, entry fields in)
//   we, w_*             - TLB write port (one-cycle write strobe)
//   entryhi_out         - current EntryHi, used as the ASID source elsewhere
// -----------------------------------------------------------------------------
module cp0_tlb_ctrl #(
   parameter int TLBNUM = 16,
   localparam int IW = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          mtc0_we,
   input  logic [7:0]    mtc0_addr,
   input  logic [31:0]   mtc0_wdata,

   input  logic [7:0]    mfc0_addr,
   output logic [31:0]   mfc0_rdata,

   input  logic          op_valid,
   input  logic          op_tlbp,
   input  logic          op_tlbr,
   input  logic          op_tlbwi,
   output logic          op_ready,
   output logic          op_done,

   output logic [18:0]   s_vpn2,
   output logic [7:0]    s_asid,
   input  logic          s_found,
   input  logic [IW-1:0] s_index,

   output logic [IW-1:0] r_index,
   input  logic [18:0]   r_vpn2,
   input  logic [7:0]    r_asid,
   input  logic          r_g,
   input  logic [19:0]   r_pfn0,
   input  logic [2:0]    r_c0,
   input  logic          r_d0,
   input  logic          r_v0,
   input  logic [19:0]   r_pfn1,
   input  logic [2:0]    r_c1,
   input  logic          r_d1,
   input  logic          r_v1,

   output logic          we,
   output logic [IW-1:0] w_index,
   output logic [18:0]   w_vpn2,
   output logic [7:0]    w_asid,
   output logic          w_g,
   output logic [19:0]   w_pfn0,
   output logic [2:0]    w_c0,
   output logic          w_d0,
   output logic          w_v0,
   output logic [19:0]   w_pfn1,
   output logic [2:0]    w_c1,
   output logic          w_d1,
   output logic          w_v1,

   output logic [31:0]   entryhi_out
);

   localparam logic [7:0] ADDR_INDEX    = 8'h00;
   localparam logic [7:0] ADDR_ENTRYLO0 = 8'h10;
   localparam logic [7:0] ADDR_ENTRYLO1 = 8'h18;
   localparam logic [7:0] ADDR_ENTRYHI  = 8'h50;

   typedef enum logic [2:0] {
      IDLE,
      PROBE,
      READ,
      WRITE,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   // Only the architecturally live bits are stored; the unused fields are
   // rebuilt as zeros on the read side.
   logic          index_p;
   logic [IW-1:0] index_val;
   logic [18:0]   entryhi_vpn2;
   logic [7:0]    entryhi_asid;
   logic [25:0]   entrylo0;
   logic [25:0]   entrylo1;

   logic [31:0]   index_word;
   logic [31:0]   entryhi_word;

   assign index_word   = {index_p, {(31-IW){1'b0}}, index_val};
   assign entryhi_word = {entryhi_vpn2, 5'b0, entryhi_asid};

   // State register; reset aborts any op in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Every op spends exactly one cycle in its work state
   // and one in DONE. Priority among simultaneous flags is tlbp, tlbr, tlbwi.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (op_valid) begin
               if (op_tlbp) begin
                  state_next = PROBE;
               end else if (op_tlbr) begin
                  state_next = READ;
               end else if (op_tlbwi) begin
                  state_next = WRITE;
               end
            end
         end
         PROBE:   state_next = DONE;
         READ:    state_next = DONE;
         WRITE:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Register updates. mtc0 is honoured only in IDLE, so a write that lands on
   // the same edge an op is accepted is already visible when the op executes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index_p      <= 1'b0;
         index_val    <= '0;
         entryhi_vpn2 <= '0;
         entryhi_asid <= '0;
         entrylo0     <= '0;
         entrylo1     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mtc0_we) begin
                  case (mtc0_addr)
                     ADDR_INDEX:    index_val <= mtc0_wdata[IW-1:0];
                     ADDR_ENTRYLO0: entrylo0  <= mtc0_wdata[25:0];
                     ADDR_ENTRYLO1: entrylo1  <= mtc0_wdata[25:0];
                     ADDR_ENTRYHI: begin
                        entryhi_vpn2 <= mtc0_wdata[31:13];
                        entryhi_asid <= mtc0_wdata[7:0];
                     end
                     default: ;
                  endcase
               end
            end
            PROBE: begin
               // A miss sets P and leaves the old index bits in place.
               if (s_found) begin
                  index_p   <= 1'b0;
                  index_val <= s_index;
               end else begin
                  index_p   <= 1'b1;
               end
            end
            READ: begin
               entryhi_vpn2 <= r_vpn2;
               entryhi_asid <= r_asid;
               entrylo0     <= {r_pfn0, r_c0, r_d0, r_v0, r_g};
               entrylo1     <= {r_pfn1, r_c1, r_d1, r_v1, r_g};
            end
            default: ;
         endcase
      end
   end

   // CP0 read mux; unmapped addresses read as zero.
   always_comb begin
      mfc0_rdata = 32'h0;
      case (mfc0_addr)
         ADDR_INDEX:    mfc0_rdata = index_word;
         ADDR_ENTRYLO0: mfc0_rdata = {6'b0, entrylo0};
         ADDR_ENTRYLO1: mfc0_rdata = {6'b0, entrylo1};
         ADDR_ENTRYHI:  mfc0_rdata = entryhi_word;
         default:       mfc0_rdata = 32'h0;
      endcase
   end

   assign op_ready    = (state == IDLE);
   assign op_done     = (state == DONE);
   assign entryhi_out = entryhi_word;

   assign s_vpn2  = entryhi_vpn2;
   assign s_asid  = entryhi_asid;
   assign r_index = index_val;

   // The write strobe is decoded from state so reset removes it immediately.
   assign we      = (state == WRITE);
   assign w_index = index_val;
   assign w_vpn2  = entryhi_vpn2;
   assign w_asid  = entryhi_asid;
   // An entry is global only if both halves agree it is.
   assign w_g     = entrylo0[0] & entrylo1[0];
   assign w_pfn0  = entrylo0[25:6];
   assign w_c0    = entrylo0[5:3];
   assign w_d0    = entrylo0[2];
   assign w_v0    = entrylo0[1];
   assign w_pfn1  = entrylo1[25:6];
   assign w_c1    = entrylo1[5:3];
   assign w_d1    = entrylo1[2];
   assign w_v1    = entrylo1[1];

endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_tlb_ctrl
//
// Directed bench for cp0_tlb_ctrl (TLBNUM = 16). Inputs change 1 ns after a
// rising edge and outputs are checked in that same gap, well away from the
// next active edge.
// -----------------------------------------------------------------------------
module tb_cp0_tlb_ctrl;

   localparam int IW = 4;

   localparam logic [7:0] A_INDEX = 8'h00;
   localparam logic [7:0] A_LO0   = 8'h10;
   localparam logic [7:0] A_LO1   = 8'h18;
   localparam logic [7:0] A_HI    = 8'h50;

   logic          clk;
   logic          reset;
   logic          mtc0_we;
   logic [7:0]    mtc0_addr;
   logic [31:0]   mtc0_wdata;
   logic [7:0]    mfc0_addr;
   logic [31:0]   mfc0_rdata;
   logic          op_valid, op_tlbp, op_tlbr, op_tlbwi;
   logic          op_ready, op_done;
   logic [18:0]   s_vpn2;
   logic [7:0]    s_asid;
   logic          s_found;
   logic [IW-1:0] s_index;
   logic [IW-1:0] r_index;
   logic [18:0]   r_vpn2;
   logic [7:0]    r_asid;
   logic          r_g;
   logic [19:0]   r_pfn0, r_pfn1;
   logic [2:0]    r_c0, r_c1;
   logic          r_d0, r_d1, r_v0, r_v1;
   logic          we;
   logic [IW-1:0] w_index;
   logic [18:0]   w_vpn2;
   logic [7:0]    w_asid;
   logic          w_g;
   logic [19:0]   w_pfn0, w_pfn1;
   logic [2:0]    w_c0, w_c1;
   logic          w_d0, w_d1, w_v0, w_v1;
   logic [31:0]   entryhi_out;

   int compared;
   int mismatched;

   cp0_tlb_ctrl #(.TLBNUM(16)) dut (
      .clk(clk), .reset(reset),
      .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
      .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
      .op_valid(op_valid), .op_tlbp(op_tlbp), .op_tlbr(op_tlbr), .op_tlbwi(op_tlbwi),
      .op_ready(op_ready), .op_done(op_done),
      .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
      .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
      .r_pfn0(r_pfn0), .r_pfn1(r_pfn1), .r_c0(r_c0), .r_c1(r_c1),
      .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1),
      .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
      .w_pfn0(w_pfn0), .w_pfn1(w_pfn1), .w_c0(w_c0), .w_c1(w_c1),
      .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1),
      .entryhi_out(entryhi_out)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts, and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Reads a CP0 register through the mfc0 port and checks it.
   task automatic checkReg(input string tag, input logic [7:0] addr,
                           input logic [31:0] expected);
      mfc0_addr = addr;
      #1;
      checkOutput(tag, mfc0_rdata, expected);
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of request inputs.
   task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                                input logic [31:0] data, input logic v,
                                input logic p, input logic r, input logic w);
      mtc0_we    = wr;
      mtc0_addr  = addr;
      mtc0_wdata = data;
      op_valid   = v;
      op_tlbp    = p;
      op_tlbr    = r;
      op_tlbwi   = w;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      idleInputs();
      mfc0_addr = 8'h00;
      s_found = 1'b0; s_index = '0;
      r_vpn2 = '0; r_asid = '0; r_g = 1'b0;
      r_pfn0 = '0; r_pfn1 = '0; r_c0 = '0; r_c1 = '0;
      r_d0 = 1'b0; r_d1 = 1'b0; r_v0 = 1'b0; r_v1 = 1'b0;

      // Reset state.
      #2;
      checkOutput("rst_op_ready", 32'(op_ready), 32'd1);
      checkOutput("rst_op_done", 32'(op_done), 32'd0);
      checkOutput("rst_we", 32'(we), 32'd0);
      checkReg("rst_index", A_INDEX, 32'h0);
      checkReg("rst_entryhi", A_HI, 32'h0);
      step();
      step();
      reset = 1'b0;

      // mtc0 EntryHi on the same edge as an accepted tlbp (hit at index 3).
      s_found = 1'b1; s_index = 4'd3;
      applyStimulus(1'b1, A_HI, 32'h0000_2005, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      idleInputs();
      checkOutput("probe_busy", 32'(op_ready), 32'd0);
      checkOutput("probe_s_vpn2", 32'(s_vpn2), 32'd1);
      checkOutput("probe_s_asid", 32'(s_asid), 32'h05);
      checkOutput("probe_done_early", 32'(op_done), 32'd0);
      checkReg("entryhi_after_mtc0", A_HI, 32'h0000_2005);
      step();
      checkOutput("probe_done", 32'(op_done), 32'd1);
      checkReg("probe_hit_index", A_INDEX, 32'h0000_0003);
      step();
      checkOutput("probe_done_once", 32'(op_done), 32'd0);
      checkOutput("probe_ready_again", 32'(op_ready), 32'd1);

      // Index = 5, then probe miss sets P and keeps the index bits.
      applyStimulus(1'b1, A_INDEX, 32'hFFFF_FFF5, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      idleInputs();
      checkReg("index_write", A_INDEX, 32'h0000_0005);
      s_found = 1'b0; s_index = 4'd12;
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      idleInputs();
      step();
      checkReg("probe_miss_index", A_INDEX, 32'h8000_0005);
      step();

      // mtc0 to Index leaves P alone; unmapped address ignores writes.
      applyStimulus(1'b1, A_INDEX, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 8'h08, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      idleInputs();
      checkReg("index_keeps_p", A_INDEX, 32'h8000_0007);
      checkReg("unmapped_reads_0", 8'h08, 32'h0);

      // EntryLo0 with G=1 (high bits dropped), EntryLo1 with G=0, then tlbwi.
      applyStimulus(1'b1, A_LO0, 32'hFC44_445F, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, A_LO1, 32'h0088_8886, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      idleInputs();
      checkReg("entrylo0_write", A_LO0, 32'h0044_445F);
      checkReg("entrylo1_write", A_LO1, 32'h0088_8886);
      checkOutput("we_idle", 32'(we), 32'd0);
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      idleInputs();
      checkOutput("wi_we", 32'(we), 32'd1);
      checkOutput("wi_w_index", 32'(w_index), 32'd7);
      checkOutput("wi_w_g", 32'(w_g), 32'd0);
      checkOutput("wi_w_pfn0", 32'(w_pfn0), 32'h11111);
      checkOutput("wi_w_pfn1", 32'(w_pfn1), 32'h22222);
      checkOutput("wi_w_c0_d0_v0", {26'b0, w_c0, w_d0, w_v0, 1'b0}, 32'h0000_001E);
      checkOutput("wi_w_c1_d1_v1", {26'b0, w_c1, w_d1, w_v1, 1'b0}, 32'h0000_0006);
      checkOutput("wi_w_vpn2_asid", {5'b0, w_vpn2, w_asid}, 32'h0000_0105);
      step();
      checkOutput("wi_we_one_cycle", 32'(we), 32'd0);
      checkOutput("wi_done", 32'(op_done), 32'd1);
      step();

      // tlbr from index 7.
      checkOutput("r_index", 32'(r_index), 32'd7);
      r_vpn2 = 19'h12345; r_asid = 8'h0A; r_g = 1'b1;
      r_pfn0 = 20'hABCDE; r_c0 = 3'd2; r_d0 = 1'b1; r_v0 = 1'b0;
      r_pfn1 = 20'h13579; r_c1 = 3'd5; r_d1 = 1'b0; r_v1 = 1'b1;
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      idleInputs();
      checkReg("read_not_yet", A_HI, 32'h0000_2005);
      step();
      checkOutput("read_done", 32'(op_done), 32'd1);
      checkReg("read_entryhi", A_HI, 32'h2468_A00A);
      checkReg("read_entrylo0", A_LO0, 32'h02AF_3795);
      checkReg("read_entrylo1", A_LO1, 32'h004D_5E6B);
      checkOutput("read_entryhi_out", entryhi_out, 32'h2468_A00A);
      step();

      // op_valid with no flag is ignored.
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      idleInputs();
      checkOutput("no_flag_stays_idle", 32'(op_ready), 32'd1);

      // tlbp+tlbwi together: probe only; mtc0 during PROBE is dropped.
      s_found = 1'b1; s_index = 4'd9;
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      applyStimulus(1'b1, A_HI, 32'hFFFF_E0FF, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("both_flags_no_we", 32'(we), 32'd0);
      step();
      idleInputs();
      checkOutput("both_flags_done", 32'(op_done), 32'd1);
      checkOutput("both_flags_no_we2", 32'(we), 32'd0);
      checkReg("probe_index_9", A_INDEX, 32'h0000_0009);
      checkReg("mtc0_dropped", A_HI, 32'h2468_A00A);
      step();

      // Reset in the middle of a tlbwi.
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      idleInputs();
      checkOutput("abort_we_before", 32'(we), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort_we_drop", 32'(we), 32'd0);
      checkOutput("abort_ready", 32'(op_ready), 32'd1);
      checkReg("abort_index", A_INDEX, 32'h0);
      checkReg("abort_entryhi", A_HI, 32'h0);
      checkReg("abort_entrylo0", A_LO0, 32'h0);
      checkReg("abort_entrylo1", A_LO1, 32'h0);
      step();
      reset = 1'b0;
      step();
      checkOutput("abort_no_done", 32'(op_done), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
